// File: rtl/qspi_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : qspi_req_arb
// Brief    : Fetch/data request arbiter for the QSPI interface, with a
//            one-deep posted write buffer and registered read-data return.
// Revision : 1.0
// ============================================================================
module qspi_req_arb #(
    parameter int ADR_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [ADR_W-1:0] i_adr,
    output logic             i_ack,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic             d_w,
    input  logic             d_hw,
    input  logic [ADR_W-1:0] d_adr,
    input  logic [31:0]      d_wdata,
    output logic             d_ack,
    output logic [31:0]      d_rdata,
    output logic             read_req,
    output logic             read_w,
    output logic             read_hw,
    output logic [31:0]      read_adr,
    input  logic             read_valid,
    input  logic [31:0]      read_data,
    output logic             write_req,
    output logic             write_w,
    output logic             write_hw,
    output logic [31:0]      write_adr,
    output logic [31:0]      write_data,
    input  logic             write_finish,
    output logic             busy
);

    localparam int c_PAD_W = 32 - ADR_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT_R = 3'd2,
        S_WAIT_W = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_last_i;
    logic             r_port_d;
    logic             r_op_wr;
    logic [ADR_W-1:0] r_rd_adr;
    logic             r_rd_w;
    logic             r_rd_hw;

    logic             r_wbuf_valid;
    logic [ADR_W-1:0] r_wbuf_adr;
    logic             r_wbuf_w;
    logic             r_wbuf_hw;
    logic [31:0]      r_wbuf_data;

    logic             r_i_ack;
    logic             r_d_ack;
    logic [31:0]      r_i_rdata;
    logic [31:0]      r_d_rdata;

    logic             w_grant_d;
    logic             w_grant_i;
    logic [31:0]      w_rd_ext;

    // Round-robin: the data port wins a tie unless it was granted last.
    assign w_grant_d = d_req & (~i_req | r_last_i);
    assign w_grant_i = i_req & ~w_grant_d;

    always_comb begin
        w_rd_ext = {24'd0, read_data[7:0]};
        if (r_rd_w) begin
            w_rd_ext = read_data;
        end else if (r_rd_hw) begin
            w_rd_ext = {16'd0, read_data[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_wbuf_valid || d_req || i_req) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = r_op_wr ? S_WAIT_W : S_WAIT_R;
            end
            S_WAIT_R: begin
                if (read_valid) begin
                    w_next_state = S_ACK;
                end
            end
            S_WAIT_W: begin
                if (write_finish) begin
                    w_next_state = S_IDLE;
                end
            end
            // The ack cycle is kept out of IDLE so a request still held
            // during its own ack is not granted a second time.
            S_ACK: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_i     <= 1'b1;
            r_port_d     <= 1'b0;
            r_op_wr      <= 1'b0;
            r_rd_adr     <= '0;
            r_rd_w       <= 1'b0;
            r_rd_hw      <= 1'b0;
            r_wbuf_valid <= 1'b0;
            r_wbuf_adr   <= '0;
            r_wbuf_w     <= 1'b0;
            r_wbuf_hw    <= 1'b0;
            r_wbuf_data  <= '0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_wbuf_valid) begin
                        r_op_wr <= 1'b1;
                    end else if (w_grant_d) begin
                        r_last_i <= 1'b0;
                        r_port_d <= 1'b1;
                        r_op_wr  <= d_we;
                        if (d_we) begin
                            // Posted: the store retires now, the transfer follows.
                            r_wbuf_valid <= 1'b1;
                            r_wbuf_adr   <= d_adr;
                            r_wbuf_w     <= d_w;
                            r_wbuf_hw    <= ~d_w & d_hw;
                            r_wbuf_data  <= d_wdata;
                            r_d_ack      <= 1'b1;
                        end else begin
                            r_rd_adr <= d_adr;
                            r_rd_w   <= d_w;
                            r_rd_hw  <= ~d_w & d_hw;
                        end
                    end else if (w_grant_i) begin
                        r_last_i <= 1'b1;
                        r_port_d <= 1'b0;
                        r_op_wr  <= 1'b0;
                        r_rd_adr <= i_adr;
                        r_rd_w   <= 1'b1;
                        r_rd_hw  <= 1'b0;
                    end
                end
                S_WAIT_R: begin
                    if (read_valid) begin
                        if (r_port_d) begin
                            r_d_rdata <= w_rd_ext;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_i_rdata <= read_data;
                            r_i_ack   <= 1'b1;
                        end
                    end
                end
                S_WAIT_W: begin
                    if (write_finish) begin
                        r_wbuf_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign i_ack      = r_i_ack;
    assign i_rdata    = r_i_rdata;
    assign d_ack      = r_d_ack;
    assign d_rdata    = r_d_rdata;
    assign read_req   = (r_state == S_ISSUE) & ~r_op_wr;
    assign read_w     = r_rd_w;
    assign read_hw    = r_rd_hw;
    assign read_adr   = {{c_PAD_W{1'b0}}, r_rd_adr};
    assign write_req  = (r_state == S_ISSUE) & r_op_wr;
    assign write_w    = r_wbuf_w;
    assign write_hw   = r_wbuf_hw;
    assign write_adr  = {{c_PAD_W{1'b0}}, r_wbuf_adr};
    assign write_data = r_wbuf_data;
    assign busy       = (r_state != S_IDLE) | r_wbuf_valid;

endmodule
`default_nettype wire

// File: tb/tb_qspi_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_req_arb
// Brief    : Transaction-timeline reference model with per-cycle comparison,
//            directed scenarios with literal expectations, then random traffic.
// Revision : 1.0
// ============================================================================
module tb_qspi_req_arb;
    localparam int ADR_W = 26;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             i_req = 1'b0;
    logic [ADR_W-1:0] i_adr = '0;
    logic             d_req = 1'b0, d_we = 1'b0, d_w = 1'b0, d_hw = 1'b0;
    logic [ADR_W-1:0] d_adr = '0;
    logic [31:0]      d_wdata = '0;
    logic             read_valid = 1'b0, write_finish = 1'b0;
    logic [31:0]      read_data = '0;
    logic             i_ack, d_ack, read_req, read_w, read_hw;
    logic             write_req, write_w, write_hw, busy;
    logic [31:0]      i_rdata, d_rdata, read_adr, write_adr, write_data;

    qspi_req_arb #(.ADR_W(ADR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_w(d_w), .d_hw(d_hw), .d_adr(d_adr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .read_req(read_req), .read_w(read_w), .read_hw(read_hw),
        .read_adr(read_adr), .read_valid(read_valid), .read_data(read_data),
        .write_req(write_req), .write_w(write_w), .write_hw(write_hw),
        .write_adr(write_adr), .write_data(write_data),
        .write_finish(write_finish), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int e       = 0;

    // Timeline model: one outstanding transaction, issue/complete edges, and
    // the first edge at which a new arbitration may take place.
    bit m_out, m_wr, m_port_d, m_last_i;
    int m_iss, m_comp, m_free;
    logic        x_read_req, x_write_req, x_i_ack, x_d_ack, x_busy;
    logic        x_rd_w, x_rd_hw, x_wr_w, x_wr_hw;
    logic [31:0] x_rd_adr, x_wr_adr, x_wr_data, x_i_rdata, x_d_rdata;

    bit          rand_mode = 1'b0;
    bit          chain_rd = 1'b0;
    int          resp_dly = 0;
    logic [31:0] rsp_val = '0;

    int last_rreq_e = -1, last_wreq_e = -1, last_iack_e = -1, last_dack_e = -1;
    int last_rv_p = -1, last_wf_p = -1, last_busy_fall = -1;
    int n_iack = 0, n_dack = 0;
    logic        prev_busy = 1'b0;
    logic        cap_rd_w, cap_rd_hw, cap_wr_w, cap_wr_hw;
    logic [31:0] cap_rd_adr, cap_wr_adr, cap_wr_data, cap_i_rdata, cap_d_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%h, expected 0x%h", name, e, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 1'b0; m_wr = 1'b0; m_port_d = 1'b0; m_last_i = 1'b1;
        m_iss = 0; m_comp = 0; m_free = 0;
        x_read_req = 1'b0; x_write_req = 1'b0; x_i_ack = 1'b0; x_d_ack = 1'b0;
        x_busy = 1'b0; x_rd_w = 1'b0; x_rd_hw = 1'b0; x_wr_w = 1'b0; x_wr_hw = 1'b0;
        x_rd_adr = '0; x_wr_adr = '0; x_wr_data = '0; x_i_rdata = '0; x_d_rdata = '0;
    endtask

    function automatic logic [31:0] zext(input logic [31:0] v, input logic w, input logic hw);
        if (w) return v;
        if (hw) return v & 32'h0000_FFFF;
        return v & 32'h0000_00FF;
    endfunction

    task automatic step();
        logic s_rst, s_ireq, s_dreq, s_we, s_w, s_hw, s_rv, s_wf;
        logic [ADR_W-1:0] s_iadr, s_dadr;
        logic [31:0] s_wd, s_rdat;
        bit gd;
        s_rst = rst_n; s_ireq = i_req; s_dreq = d_req; s_we = d_we; s_w = d_w; s_hw = d_hw;
        s_rv = read_valid; s_wf = write_finish; s_iadr = i_adr; s_dadr = d_adr;
        s_wd = d_wdata; s_rdat = read_data;
        @(posedge clk);
        e++;
        x_read_req = 1'b0; x_write_req = 1'b0; x_i_ack = 1'b0; x_d_ack = 1'b0;
        if (!s_rst) begin
            model_reset();
        end else if (m_out && e >= m_iss + 2 && (m_wr ? s_wf : s_rv)) begin
            m_out = 1'b0;
            if (m_wr) begin
                m_free = e + 1;
            end else begin
                m_free = e + 2;
                if (m_port_d) begin
                    x_d_ack = 1'b1; x_d_rdata = zext(s_rdat, x_rd_w, x_rd_hw);
                end else begin
                    x_i_ack = 1'b1; x_i_rdata = s_rdat;
                end
            end
        end else if (!m_out && e >= m_free && (s_ireq || s_dreq)) begin
            gd = s_dreq && (!s_ireq || m_last_i);
            m_last_i = !gd; m_port_d = gd; m_wr = gd && s_we;
            m_out = 1'b1; m_iss = e; m_comp = e + 2 + resp_dly;
            if (m_wr) begin
                x_write_req = 1'b1; x_d_ack = 1'b1;
                x_wr_adr = 32'(s_dadr); x_wr_w = s_w; x_wr_hw = !s_w && s_hw; x_wr_data = s_wd;
            end else begin
                x_read_req = 1'b1;
                x_rd_adr = gd ? 32'(s_dadr) : 32'(s_iadr);
                x_rd_w   = gd ? s_w : 1'b1;
                x_rd_hw  = gd ? (!s_w && s_hw) : 1'b0;
            end
        end
        x_busy = m_out ? 1'b1 : (e < m_free - 1);
        @(negedge clk);
        chk("read_req", 32'(read_req), 32'(x_read_req));
        chk("write_req", 32'(write_req), 32'(x_write_req));
        chk("i_ack", 32'(i_ack), 32'(x_i_ack));
        chk("d_ack", 32'(d_ack), 32'(x_d_ack));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("read_adr", read_adr, x_rd_adr);
        chk("read_w", 32'(read_w), 32'(x_rd_w));
        chk("read_hw", 32'(read_hw), 32'(x_rd_hw));
        chk("write_adr", write_adr, x_wr_adr);
        chk("write_w", 32'(write_w), 32'(x_wr_w));
        chk("write_hw", 32'(write_hw), 32'(x_wr_hw));
        chk("write_data", write_data, x_wr_data);
        chk("i_rdata", i_rdata, x_i_rdata);
        chk("d_rdata", d_rdata, x_d_rdata);
        if (read_req) begin
            last_rreq_e = e; cap_rd_adr = read_adr; cap_rd_w = read_w; cap_rd_hw = read_hw;
        end
        if (write_req) begin
            last_wreq_e = e; cap_wr_adr = write_adr; cap_wr_w = write_w;
            cap_wr_hw = write_hw; cap_wr_data = write_data;
        end
        if (i_ack) begin last_iack_e = e; cap_i_rdata = i_rdata; n_iack++; end
        if (d_ack) begin last_dack_e = e; cap_d_rdata = d_rdata; n_dack++; end
        if (prev_busy && !busy) last_busy_fall = e;
        prev_busy = busy;
        // Masters and interface responder drive the next period's inputs.
        if (x_i_ack) i_req = 1'b0;
        if (x_d_ack) begin
            d_req = 1'b0;
            if (chain_rd) begin
                d_req = 1'b1; d_we = 1'b0; d_w = 1'b1; d_hw = 1'b0; d_adr = 26'h40;
                chain_rd = 1'b0;
            end
        end
        if (rand_mode) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_adr = ADR_W'($urandom);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_w = 1'($urandom_range(0, 1));
                d_hw = 1'($urandom_range(0, 1)); d_adr = ADR_W'($urandom); d_wdata = $urandom;
            end
            resp_dly = $urandom_range(0, 3);
        end
        read_valid   = m_out && !m_wr && (e + 1 == m_comp);
        write_finish = m_out && m_wr && (e + 1 == m_comp);
        if (rand_mode && !x_busy && $urandom_range(0, 7) == 0) read_valid = 1'b1;
        if (rand_mode && !x_busy && $urandom_range(0, 7) == 0) write_finish = 1'b1;
        read_data = rand_mode ? $urandom : rsp_val;
        if (read_valid) last_rv_p = e;
        if (write_finish) last_wf_p = e;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_quiet(input string name, input int bound);
        int k;
        k = 0;
        while ((i_req || d_req || m_out || e < m_free) && k < bound) begin
            step();
            k++;
        end
        if (k >= bound) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: still busy after %0d cycles, expected idle", name, bound);
        end
    endtask

    int t0, ni, nd;

    initial begin
        model_reset();
        run(3);
        rst_n = 1'b1;
        run(2);

        // Fetch only.
        rsp_val = 32'hDEADBEEF; resp_dly = 1;
        i_req = 1'b1; i_adr = 26'h000100; t0 = e;
        wait_quiet("fetch", 40);
        chk("fetch_rreq_latency", 32'(last_rreq_e - t0), 32'd1);
        chk("fetch_read_adr", cap_rd_adr, 32'h0000_0100);
        chk("fetch_read_w", 32'(cap_rd_w), 32'd1);
        chk("fetch_ack_latency", 32'(last_iack_e - last_rv_p), 32'd1);
        chk("fetch_i_rdata", cap_i_rdata, 32'hDEADBEEF);

        // Ties: data port wins after an instruction grant; alternation continues.
        rsp_val = 32'h1111_2222; resp_dly = 0;
        i_req = 1'b1; i_adr = 26'h200; d_req = 1'b1; d_we = 1'b0; d_w = 1'b1; d_adr = 26'h300;
        wait_quiet("tie1", 40);
        chk("tie1_d_first", 32'(last_dack_e < last_iack_e), 32'd1);
        i_req = 1'b1; d_req = 1'b1;
        wait_quiet("tie2", 40);
        chk("tie2_d_first", 32'(last_dack_e < last_iack_e), 32'd1);
        d_req = 1'b1;
        wait_quiet("d_alone", 40);
        i_req = 1'b1; d_req = 1'b1;
        wait_quiet("tie3", 40);
        chk("tie3_i_first", 32'(last_iack_e < last_dack_e), 32'd1);

        // Posted byte write.
        resp_dly = 2;
        d_req = 1'b1; d_we = 1'b1; d_w = 1'b0; d_hw = 1'b0; d_adr = 26'h1000003; d_wdata = 32'hA5;
        t0 = e;
        wait_quiet("posted_write", 40);
        chk("pw_ack_latency", 32'(last_dack_e - t0), 32'd1);
        chk("pw_wreq_latency", 32'(last_wreq_e - t0), 32'd1);
        chk("pw_write_adr", cap_wr_adr, 32'h0100_0003);
        chk("pw_write_w", 32'(cap_wr_w), 32'd0);
        chk("pw_write_hw", 32'(cap_wr_hw), 32'd0);
        chk("pw_write_data", cap_wr_data, 32'h0000_00A5);
        chk("pw_busy_until_finish", 32'(last_busy_fall - last_wf_p), 32'd1);

        // Read queued behind a buffered write to the same address.
        resp_dly = 3; rsp_val = 32'h1234_5678; nd = n_dack; chain_rd = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_w = 1'b1; d_adr = 26'h40; d_wdata = 32'h1234_5678;
        wait_quiet("read_after_write", 60);
        chk("raw_d_acks", 32'(n_dack - nd), 32'd2);
        chk("raw_rreq_after_finish", 32'(last_rreq_e - last_wf_p), 32'd2);
        chk("raw_ack_after_valid", 32'(last_dack_e - last_rv_p), 32'd1);
        chk("raw_d_rdata", cap_d_rdata, 32'h1234_5678);

        // Size priority and zero extension.
        resp_dly = 0; rsp_val = 32'hCAFE_F00D;
        d_req = 1'b1; d_we = 1'b0; d_w = 1'b1; d_hw = 1'b1; d_adr = 26'h55;
        wait_quiet("size_prio", 40);
        chk("sz_read_w", 32'(cap_rd_w), 32'd1);
        chk("sz_read_hw", 32'(cap_rd_hw), 32'd0);
        chk("sz_d_rdata", cap_d_rdata, 32'hCAFE_F00D);
        d_req = 1'b1; d_w = 1'b0; d_hw = 1'b1;
        wait_quiet("hw_read", 40);
        chk("hw_d_rdata", cap_d_rdata, 32'h0000_F00D);

        // Spurious completions in idle, then reset during WAIT_R.
        ni = n_iack; nd = n_dack;
        read_valid = 1'b1; write_finish = 1'b1;
        run(3);
        chk("spurious_no_ack", 32'((n_iack - ni) + (n_dack - nd)), 32'd0);
        resp_dly = 3; i_req = 1'b1; i_adr = 26'h3AA;
        for (int k = 0; k < 20 && last_rreq_e != e; k++) step();
        step();
        rst_n = 1'b0; i_req = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read_adr", read_adr, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        rsp_val = 32'h0BAD_F00D; resp_dly = 1;
        i_req = 1'b1; i_adr = 26'h3BC;
        wait_quiet("after_reset", 40);
        chk("post_rst_adr", cap_rd_adr, 32'h0000_03BC);
        chk("post_rst_i_rdata", cap_i_rdata, 32'h0BAD_F00D);

        // Random traffic against the model.
        rand_mode = 1'b1;
        run(3000);
        rand_mode = 1'b0;
        resp_dly = 0;
        wait_quiet("drain", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
